// File: rtl/comm_arbiter.sv
// comm_arbiter: buffers one request per lane and issues the largest conflict-free subset each cycle
module comm_arbiter #(
  parameter int nIN  = 12,
  parameter int nOUT = 32,
  parameter int wD   = 38,
  parameter int wCNT = 16,
  localparam int wA  = $clog2(nOUT),
  localparam int wP  = $clog2(nIN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [nIN-1:0]    in_valid,
  output logic [nIN-1:0]    in_ready,
  input  logic [nIN*wD-1:0] in_data,
  input  logic [nIN*wA-1:0] in_addr,
  output logic [nIN-1:0]    req_out,
  output logic [nIN*wD-1:0] data_out,
  output logic [nIN*wA-1:0] addr_out,
  input  logic              clr_cnt,
  output logic [wCNT-1:0]   conflict_cnt
);
  logic [nIN-1:0] hv, gnt;
  logic [wD-1:0]  hd [nIN];
  logic [wA-1:0]  ha [nIN];
  logic [wP-1:0]  ptr, nptr;
  logic           any_den;

  assign in_ready = ~hv | gnt;
  assign any_den  = |(hv & ~gnt);

  // walk lanes in rotating order from ptr; a lane loses only to an earlier granted lane with the same channel
  always_comb begin
    logic [nIN-1:0] g;
    logic [wP-1:0]  l, m;
    logic           blk;
    g    = '0;
    l    = '0;
    m    = '0;
    blk  = 1'b0;
    nptr = ptr;
    for (int k = 0; k < nIN; k++) begin
      l   = wP'((int'(ptr) + k) % nIN);
      blk = 1'b0;
      for (int j = 0; j < k; j++) begin
        m   = wP'((int'(ptr) + j) % nIN);
        blk = blk | (g[m] & (ha[m] == ha[l]));
      end
      g[l] = hv[l] & ~blk;
    end
    for (int k = nIN - 1; k >= 0; k--) begin
      l    = wP'((int'(ptr) + k) % nIN);
      nptr = (hv[l] & ~g[l]) ? l : nptr;
    end
    gnt = g;
  end

  // entry valid flags: load on accept, free when issued with no replacement
  always_ff @(posedge clk or negedge reset)
    if (!reset) hv <= '0;
    else
      for (int i = 0; i < nIN; i++)
        if (in_valid[i] && in_ready[i]) hv[i] <= 1'b1;
        else if (gnt[i]) hv[i] <= 1'b0;

  // entry payload and channel, captured on accept
  always_ff @(posedge clk)
    for (int i = 0; i < nIN; i++)
      if (in_valid[i] && in_ready[i]) begin
        hd[i] <= in_data[i*wD +: wD];
        ha[i] <= in_addr[i*wA +: wA];
      end

  // issue registers, priority pointer and saturating conflict counter
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      req_out      <= '0;
      data_out     <= '0;
      addr_out     <= '0;
      ptr          <= '0;
      conflict_cnt <= '0;
    end else begin
      req_out <= gnt;
      for (int i = 0; i < nIN; i++)
        if (gnt[i]) begin
          data_out[i*wD +: wD] <= hd[i];
          addr_out[i*wA +: wA] <= ha[i];
        end
      ptr <= nptr;
      if (clr_cnt) conflict_cnt <= '0;
      else if (any_den && !(&conflict_cnt)) conflict_cnt <= conflict_cnt + 1'b1;
    end
endmodule

// File: tb/tb_comm_arbiter.sv
// tb_comm_arbiter: directed stimulus with per-lane scoreboard for comm_arbiter
module tb_comm_arbiter;
  localparam int NI = 12;
  localparam int WD = 38;
  localparam int WA = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NI-1:0]     in_valid = '0;
  logic [NI-1:0]     in_ready;
  logic [NI*WD-1:0]  in_data = '0;
  logic [NI*WA-1:0]  in_addr = '0;
  logic [NI-1:0]     req_out;
  logic [NI*WD-1:0]  data_out;
  logic [NI*WA-1:0]  addr_out;
  logic              clr_cnt = 1'b0;
  logic [15:0]       conflict_cnt;

  int passed = 0;
  int total  = 0;
  logic [WA+WD-1:0] sb [NI][$];
  logic [NI-1:0]    ren = '0;
  logic [33:0]      seq = '0;

  comm_arbiter dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_addr(in_addr), .req_out(req_out),
    .data_out(data_out), .addr_out(addr_out), .clr_cnt(clr_cnt),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic req(int i, logic [WA-1:0] a, logic [WD-1:0] d);
    in_valid[i] = 1'b1;
    in_addr[i*WA +: WA] = a;
    in_data[i*WD +: WD] = d;
  endtask

  // push accepted requests, let the edge pass, refresh data on re-presenting lanes, wait for sample point
  task automatic cyc();
    logic [NI-1:0] acc;
    acc = in_valid & in_ready;
    for (int i = 0; i < NI; i++)
      if (acc[i]) sb[i].push_back({in_addr[i*WA +: WA], in_data[i*WD +: WD]});
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++)
      if (acc[i] && ren[i]) begin
        seq = seq + 1'b1;
        in_data[i*WD +: WD] = {i[3:0], seq};
      end
    @(negedge clk);
  endtask

  // every issued lane must match the oldest outstanding request of that lane
  always @(negedge clk)
    if (reset)
      for (int i = 0; i < NI; i++)
        if (req_out[i]) begin
          chk($sformatf("stale_l%0d", i), 64'(sb[i].size() != 0), 64'd1);
          if (sb[i].size() != 0)
            chk($sformatf("issue_l%0d", i), 64'({addr_out[i*WA +: WA], data_out[i*WD +: WD]}), 64'(sb[i].pop_front()));
        end

  initial begin
    logic [NI-1:0] served;
    int pend;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(in_ready), 64'hFFF);
    chk("rst_req", 64'(req_out), 64'h0);
    chk("rst_cnt", 64'(conflict_cnt), 64'h0);
    chk("rst_data", 64'(|data_out | |addr_out), 64'h0);
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cyc();
      chk("idle_ready", 64'(in_ready), 64'hFFF);
      chk("idle_req", 64'(req_out), 64'h0);
      chk("idle_cnt", 64'(conflict_cnt), 64'h0);
    end

    for (int i = 0; i < NI; i++) req(i, WA'(i), WD'(i + 100));
    cyc();
    in_valid = '0;
    chk("all_lat0", 64'(req_out), 64'h0);
    chk("all_ready", 64'(in_ready), 64'hFFF);
    cyc();
    chk("all_req", 64'(req_out), 64'hFFF);
    chk("all_lane5_data", 64'(data_out[5*WD +: WD]), 64'd105);
    chk("all_lane11_addr", 64'(addr_out[11*WA +: WA]), 64'd11);
    chk("all_cnt", 64'(conflict_cnt), 64'h0);

    req(3, 5'd5, 38'h333);
    req(7, 5'd5, 38'h777);
    cyc();
    in_valid = '0;
    chk("cf_ready", 64'(in_ready), 64'hF7F);
    chk("cf_req0", 64'(req_out), 64'h0);
    cyc();
    chk("cf_req3", 64'(req_out), 64'h008);
    chk("cf_cnt", 64'(conflict_cnt), 64'd1);
    chk("cf_ready2", 64'(in_ready), 64'hFFF);
    cyc();
    chk("cf_req7", 64'(req_out), 64'h080);
    chk("cf_cnt2", 64'(conflict_cnt), 64'd1);
    cyc();
    chk("cf_idle", 64'(req_out), 64'h0);

    ren = '1;
    for (int i = 0; i < NI; i++) req(i, 5'd9, {i[3:0], 34'h0});
    cyc();
    chk("rr_lat0", 64'(req_out), 64'h0);
    served = '0;
    for (int c = 0; c < 3 * NI; c++) begin
      cyc();
      if (c == 0) chk("rr_first", 64'(req_out), 64'h080);
      chk("rr_onehot", 64'($countones(req_out)), 64'd1);
      chk("rr_fair", 64'(served & req_out), 64'h0);
      served = served | req_out;
      if (served == '1) served = '0;
    end
    ren = '0;
    in_valid = '0;
    repeat (NI + 2) cyc();
    pend = 0;
    for (int i = 0; i < NI; i++) pend += sb[i].size();
    chk("rr_drained", 64'(pend), 64'd0);
    chk("rr_cnt_nz", 64'(conflict_cnt != 0), 64'd1);

    req(0, 5'd2, 38'h100);
    req(1, 5'd2, 38'h101);
    cyc();
    in_valid = '0;
    chk("clr_denied", 64'($countones(~in_ready & 12'h003)), 64'd1);
    clr_cnt = 1'b1;
    cyc();
    clr_cnt = 1'b0;
    chk("clr_prio", 64'(conflict_cnt), 64'd0);
    cyc();
    chk("clr_noinc", 64'(conflict_cnt), 64'd0);
    repeat (3) cyc();

    ren = '1;
    for (int i = 0; i < NI; i++) req(i, 5'd9, {i[3:0], 34'h0});
    repeat (65600) cyc();
    chk("sat_reach", 64'(conflict_cnt), 64'hFFFF);
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("sat_hold", 64'(conflict_cnt), 64'hFFFF);
    end
    ren = '0;
    in_valid = '0;
    repeat (NI + 2) cyc();

    for (int i = 0; i < 5; i++) req(i, 5'd3, WD'(i + 200));
    cyc();
    in_valid = '0;
    chk("mid_ready", 64'(in_ready), 64'hFE1);
    #2 reset = 1'b0;
    #1;
    chk("mid_req", 64'(req_out), 64'h0);
    chk("mid_out", 64'(|data_out | |addr_out), 64'h0);
    chk("mid_ready_rst", 64'(in_ready), 64'hFFF);
    chk("mid_cnt", 64'(conflict_cnt), 64'h0);
    for (int i = 0; i < NI; i++) sb[i].delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      cyc();
      chk("post_req", 64'(req_out), 64'h0);
    end
    chk("post_ready", 64'(in_ready), 64'hFFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/comm_arbiter.md
# comm_arbiter

Conflict-resolving front-end scheduler for the pipelined commutator. It accepts one request per input lane through a valid/ready handshake and holds each in a single-entry buffer. Every cycle it issues the largest conflict-free subset to the commutator: no two lanes may target the same output channel in the same cycle. Its registered outputs drive the pre-commutator adapter's req/data/addr inputs directly, replacing the free-running input shift register as the commutator's source.

## Interface
- nIN, 12, number of input lanes
- nOUT, 32, number of commutator output channels; wA = $clog2(nOUT)
- wD, 38, payload width per lane
- wCNT, 16, width of conflict counter
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  asynchronous, active-low; clears all state
- in_valid  in  nIN  lane i holds a request
- in_ready  out  nIN  lane i buffer can accept this cycle
- in_data  in  nIN*wD  lane i payload at [i*wD +: wD]
- in_addr  in  nIN*wA  lane i output channel at [i*wA +: wA]
- req_out  out  nIN  lane i issued to commutator this cycle
- data_out  out  nIN*wD  issued payloads, lane-aligned with in_data
- addr_out  out  nIN*wA  issued channels, lane-aligned with in_addr
- clr_cnt  in  1  synchronous clear of conflict_cnt
- conflict_cnt  out  wCNT  saturating count of cycles with at least one denied lane

## Operation
- Per-lane hold register: hv[i], hd[i], ha[i].
- in_ready[i] = ~hv[i] | gnt[i]. This is combinational from state only and never depends on in_valid.
- Accept on the edge where in_valid[i] & in_ready[i]: hv[i]<=1, hd/ha<=in_data/in_addr. If gnt[i] & ~in_valid[i], hv[i]<=0.
- Rotating priority pointer ptr, range 0..nIN-1. Order is ptr, ptr+1, …, wrapping mod nIN.
- Grant (combinational): lane i is granted iff hv[i]=1 and no lane earlier in the order is both granted and has ha equal to ha[i].
- Addresses ≥ nOUT are legal inputs and arbitrate like any other value. The commutator discards them; this block does not check them.
- Denied lane: hv[i]=1 & ~gnt[i]. It keeps its entry and in_ready[i]=0.
- ptr update: if any lane is denied, ptr<= the first denied lane in current order. Otherwise ptr holds.
- Starvation bound: a held entry is issued within nIN cycles.
- Output registers (one per lane, every edge): req_out[i]<=gnt[i]; data_out/addr_out lane i <= hd[i]/ha[i] when gnt[i], else hold previous value.
- conflict_cnt: clr_cnt=1 → 0 (clear has priority over increment); else +1 on any cycle with ≥1 denied lane, saturating at 2^wCNT−1.

## Timing
- Reset (async assert, sync-safe deassert by the system) values:
  - hv=0, ptr=0, req_out=0, data_out=0, addr_out=0, conflict_cnt=0.
  - in_ready=all ones, because hv=0.
- Reset mid-operation discards all held entries without issuing them.
- Latency: a request accepted at edge k and granted in cycle k has req_out=1 for exactly one cycle after edge k+1. Minimum latency is 1 cycle from acceptance.
- Back-to-back throughput: a lane granted every cycle accepts a new request every cycle. Full rate is 1 per lane per cycle when there are no conflicts.
- Simultaneous grant and new valid on the same lane: the new entry loads, hv stays 1, and nothing is lost.
- Conflict counter and ptr update on the same edge as the outputs.
- No combinational path from any input to any output except in_ready. in_ready depends only on registers and on gnt, which is itself computed from registers.

## Test plan
- Reset release, all in_valid=0 → in_ready=all ones, req_out=0, conflict_cnt=0. Hold for 10 cycles; nothing changes.
- Lanes 0..11 each assert one request with addr=i, data=i+100 at edge 0 → req_out=0xFFF one cycle after edge 1, data/addr lane i = i+100/i, conflict_cnt=0.
- Lanes 3 and 7 both with addr=5, ptr=0 → lane 3 issues first, lane 7 issues the next cycle. in_ready[7]=0 for one cycle, ptr becomes 7, conflict_cnt=1.
- All 12 lanes hold addr=9 continuously (re-presenting every cycle) → exactly one req_out bit per cycle. Every lane is served within 12 cycles and no lane is served twice before all others are served once.
- clr_cnt=1 on the same cycle as a conflict → conflict_cnt=0 next cycle. Separately, force the counter to 0xFFFF with continuous conflicts → the counter stays at 0xFFFF.
- Assert reset mid-stream with 5 lanes holding entries → all outputs 0 immediately and in_ready all ones. After release, no stale entry is ever issued.
